// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word-incrementing burst reads from the fetch PC,
// buffers returned words with their PCs in a prefetch FIFO and hands them to decode
// over a valid/ready handshake. A redirect flushes everything and restarts at a new PC.
module fetch_unit #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned BURST_WORDS = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h8002_0000
) (
    input  logic                  clock,
    input  logic                  reset_n,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [1:0]            mem_access_size,
    output logic                  mem_rw,
    output logic                  mem_enable,
    input  logic                  mem_busy,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  insn_valid,
    input  logic                  insn_ready,
    output logic [DATA_WIDTH-1:0] insn_out,
    output logic [ADDR_WIDTH-1:0] insn_pc
);

    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BEAT_W = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;
    localparam logic [1:0] SIZE_CODE = (BURST_WORDS == 16) ? 2'b11 :
                                       (BURST_WORDS == 8)  ? 2'b10 :
                                       (BURST_WORDS == 4)  ? 2'b01 : 2'b00;

    typedef enum logic [0:0] {StIdle, StReq} state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   fetch_pc_q;
    logic [BEAT_W-1:0]       beat_q;
    logic                    pending_q;
    logic [ADDR_WIDTH-1:0]   pending_pc_q;

    logic [DATA_WIDTH-1:0]   data_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]   pc_mem   [FIFO_DEPTH];
    logic [PTR_W-1:0]        rd_ptr_q;
    logic [PTR_W-1:0]        wr_ptr_q;
    logic [CNT_W-1:0]        count_q;

    logic accept;
    logic start_ok;
    logic push;
    logic pop;
    logic unused_redirect_lsbs;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // The fetch PC always points at the beat being requested, so it doubles as the address.
    assign mem_enable      = (state_q == StReq);
    assign mem_address     = mem_enable ? fetch_pc_q : '0;
    assign mem_access_size = SIZE_CODE;
    assign mem_rw          = 1'b0;

    assign accept   = mem_enable && !mem_busy;
    // Reserve a whole burst of slots up front, counting a word still on its way back.
    assign start_ok = (32'(count_q) + 32'(pending_q) + BURST_WORDS) <= FIFO_DEPTH;

    assign insn_valid = (count_q != '0);
    assign insn_out   = insn_valid ? data_mem[rd_ptr_q] : '0;
    assign insn_pc    = insn_valid ? pc_mem[rd_ptr_q]   : '0;

    // Redirect kills both the returning word and any decode pop in the same cycle.
    assign push = pending_q && !redirect;
    assign pop  = insn_valid && insn_ready && !redirect;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Fetch FSM: burst sequencing, PC advance and return tracking.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            fetch_pc_q   <= RESET_PC;
            beat_q       <= '0;
            pending_q    <= 1'b0;
            pending_pc_q <= '0;
        end else if (redirect) begin
            state_q    <= StReq;
            fetch_pc_q <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            beat_q     <= '0;
            pending_q  <= 1'b0;
        end else begin
            pending_q    <= accept;
            pending_pc_q <= fetch_pc_q;
            unique case (state_q)
                StIdle: begin
                    beat_q <= '0;
                    if (start_ok) state_q <= StReq;
                end
                StReq: begin
                    if (accept) begin
                        fetch_pc_q <= fetch_pc_q + ADDR_WIDTH'(4);
                        if (beat_q == BEAT_W'(BURST_WORDS - 1)) begin
                            beat_q  <= '0;
                            state_q <= StIdle;
                        end else begin
                            beat_q <= beat_q + BEAT_W'(1);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Prefetch FIFO pointers and occupancy.
    always_ff @(posedge clock) begin
        if (!reset_n || redirect) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Prefetch FIFO storage; contents are only meaningful below the count.
    always_ff @(posedge clock) begin
        if (push) begin
            data_mem[wr_ptr_q] <= mem_data_out;
            pc_mem[wr_ptr_q]   <= pending_pc_q;
        end
    end

endmodule
